seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Four-digit 7-segment display controller that fetches its digit values from data memory over a shared request/grant read port. It scans the anodes from a double-buffered digit register file, so the display never shows a half-updated frame. It sits between the data-memory arbiter and the board `an`/`seg` pins, and replaces direct combinational taps into the RAM array.

## Interface
Parameters:
- `BASE_ADDR`, 0: word index of digit 0 (leftmost). Digits occupy `BASE_ADDR`..`BASE_ADDR+3`.
- `REFRESH_BITS`, 18: each digit is lit for 2^`REFRESH_BITS` cycles. One frame is 4·2^`REFRESH_BITS` cycles.

Ports:
- `clk`, input, 1: system clock. One clock domain only.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: when high, a memory fetch is launched at every frame start.
- `mem_req`, output, 1: read request to the data-memory arbiter.
- `mem_addr`, output, 32: word index of the requested read.
- `mem_gnt`, input, 1: grant from the arbiter. `mem_rdata` is valid in the same cycle.
- `mem_rdata`, input, 32: read data. Only bits [3:0] are used.
- `an`, output, 4: anode selects, active-low.
- `seg`, output, 7: cathodes, active-low, bit order GFEDCBA.
- `dp`, output, 1: decimal point, active-low. Held at 1 (off).
- `frame_done`, output, 1: single-cycle pulse when a new buffer is committed.

## Operation
- Refresh counter `rc`: `REFRESH_BITS+2` bits, free-running, wraps modulo 2^(`REFRESH_BITS`+2). Digit select `sel = rc[top:top-1]`.
- Frame start: the cycle in which `rc == 0`.
- Fetch FSM states:
  - IDLE: at frame start with `enable=1`, go to FETCH with `k=0`.
  - FETCH: `mem_req=1` and `mem_addr=BASE_ADDR+k`. Both are held stable until `mem_gnt=1`.
    - On grant, `shadow[k] <= mem_rdata[3:0]`.
    - If `k<3`, increment `k` and stay in FETCH.
    - If `k==3`, go to COMMIT.
  - COMMIT: for one cycle, `disp[0..3] <= shadow[0..3]`, `valid <= 1`, `frame_done=1`. Then go to IDLE.
- Frame starts that occur outside IDLE are dropped, not queued. A stalled grant therefore stretches the fetch across frames. The display keeps showing the old `disp` meanwhile.
- `enable` falling mid-fetch does not abort the fetch; it completes and commits.
- `mem_req` is low in IDLE and COMMIT. `mem_addr` holds 0 when not requesting.
- Digit/anode mapping:
  - `sel` 0 → `an=0111`, `disp[0]`
  - `sel` 1 → `an=1011`, `disp[1]`
  - `sel` 2 → `an=1101`, `disp[2]`
  - `sel` 3 → `an=1110`, `disp[3]`
- Decoder uses active-low GFEDCBA patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011, C=0100111, D=0100001, E=0000110, F=0001110
  - dash=0111111
- While `valid=0` (no frame committed since reset), every digit shows dash.

## Timing
- Reset values:
  - `an=1111`, `seg=0111111`, `dp=1`, `mem_req=0`, `mem_addr=0`, `frame_done=0`.
  - `rc=0`, FSM in IDLE, `valid=0`, `shadow` and `disp` all 0.
- Reset asserted mid-fetch aborts immediately. `mem_req` drops asynchronously.
- After reset release, the first frame start is the first rising edge with `rc==0`. The FSM enters FETCH on that edge, so `mem_req` rises one cycle later.
- A fetch with `mem_gnt` tied high takes 4 cycles in FETCH plus 1 cycle in COMMIT. `frame_done` pulses 5 cycles after frame start is sampled.
- `an` and `seg` are registered and lag `sel` by one cycle. `an` and `seg` always change on the same edge; no glitch combination is allowed.
- Updating `disp` in the same cycle as a `sel` change is legal. The next registered `seg` reflects the new `disp`.

## Configuration
- `SEG_SCAN_LZ_BLANK_EN`:
  - Defined: leading-zero blanking is on. Digits 0..2 whose value is 0 are blanked (`an` bit held 1) when every digit to their left is also 0. Digit 3 is never blanked. Example: `disp`=0,0,4,0 lights only digits 2 and 3.
  - Undefined: all four digits are always lit.
- The macro does not affect dash display while `valid=0`.

## Test plan
- Reset, then `REFRESH_BITS=2`, `enable=1`, `mem_gnt=1`, memory words 0..3 = 1,2,2,2:
  - `mem_addr` sequence is 0,1,2,3.
  - `frame_done` pulses once.
  - In the next frame, `an`/`seg` cycle through 0111/1111001, 1011/0100100, 1101/0100100, 1110/0100100.
- Grant stall: hold `mem_gnt=0` for 40 cycles during `k=1`:
  - `mem_req=1` and `mem_addr=BASE_ADDR+1` stay stable throughout.
  - Missed frame starts are dropped.
  - Old digits remain on the display.
  - Exactly one `frame_done` follows the release of the stall.
- Before the first commit (`enable=0` after reset):
  - All digits show 0111111.
  - `mem_req` never rises.
- Pulse `reset_n` low during FETCH with `k=2`:
  - `mem_req` drops at once.
  - Outputs return to their reset values and `valid=0`.
  - After release, fetching restarts at `k=0`.
- `BASE_ADDR=8` with word 8 = 0x1F (only [3:0] used):
  - Digit 0 shows F (0001110).
  - Upper data bits are ignored.
- With `SEG_SCAN_LZ_BLANK_EN` defined and `disp`=0,0,0,0:
  - Only `an=1110` is ever asserted, showing 1000000.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit 7-segment scanner fed from data memory via req/gnt reads
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
  parameter int BASE_ADDR    = 0,
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int RC_W = REFRESH_BITS + 2;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RC_W-1:0] r_rc;
  logic [1:0]      r_k;
  logic [1:0]      w_k_nxt;
  logic [3:0]      r_shadow [4];
  logic [3:0]      r_disp   [4];
  logic            r_valid;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            w_frame_start;
  logic [1:0]      w_sel;
  logic            w_shadow_we;
  logic            w_commit;
  logic            w_blank;
  logic [3:0]      w_an_nxt;
  logic [6:0]      w_seg_nxt;
  logic            w_unused_rdata;

  assign w_frame_start  = (r_rc == '0);
  assign w_sel          = r_rc[RC_W-1 -: 2];
  assign w_unused_rdata = ^mem_rdata[31:4];

  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    case (v)
      4'h0: f_seg7 = 7'b1000000;
      4'h1: f_seg7 = 7'b1111001;
      4'h2: f_seg7 = 7'b0100100;
      4'h3: f_seg7 = 7'b0110000;
      4'h4: f_seg7 = 7'b0011001;
      4'h5: f_seg7 = 7'b0010010;
      4'h6: f_seg7 = 7'b0000010;
      4'h7: f_seg7 = 7'b1111000;
      4'h8: f_seg7 = 7'b0000000;
      4'h9: f_seg7 = 7'b0010000;
      4'hA: f_seg7 = 7'b0001000;
      4'hB: f_seg7 = 7'b0000011;
      4'hC: f_seg7 = 7'b0100111;
      4'hD: f_seg7 = 7'b0100001;
      4'hE: f_seg7 = 7'b0000110;
      default: f_seg7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rc    <= '0;
      r_state <= S_IDLE;
      r_k     <= 2'd0;
    end else begin
      r_rc    <= r_rc + 1'b1;
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Frame starts seen outside IDLE are simply ignored, so a stalled grant stretches one fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_shadow_we = 1'b0;
    w_commit    = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = 32'd0;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_start && enable) begin
          w_state_nxt = S_FETCH;
          w_k_nxt     = 2'd0;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = 32'(BASE_ADDR) + {30'd0, r_k};
        if (mem_gnt) begin
          w_shadow_we = 1'b1;
          if (r_k == 2'd3) begin
            w_state_nxt = S_COMMIT;
          end else begin
            w_k_nxt = r_k + 2'd1;
          end
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= 4'd0;
        r_disp[i]   <= 4'd0;
      end
      r_valid <= 1'b0;
    end else begin
      if (w_shadow_we) begin
        r_shadow[r_k] <= mem_rdata[3:0];
      end
      if (w_commit) begin
        for (int i = 0; i < 4; i++) begin
          r_disp[i] <= r_shadow[i];
        end
        r_valid <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    case (w_sel)
      2'd0: w_blank = (r_disp[0] == 4'd0);
      2'd1: w_blank = (r_disp[0] == 4'd0) && (r_disp[1] == 4'd0);
      2'd2: w_blank = (r_disp[0] == 4'd0) && (r_disp[1] == 4'd0) && (r_disp[2] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  // an and seg come from the same register stage so they can never disagree for a cycle.
  always_comb begin
    w_an_nxt  = 4'b1111 ^ (4'b1000 >> w_sel);
    w_seg_nxt = SEG_DASH;
    if (r_valid) begin
      if (w_blank) begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
      end else begin
        w_seg_nxt = f_seg7(r_disp[w_sel]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_DASH;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule
